// File: rtl/dispensador_troco.sv
// dispensador_troco: change dispenser, one solenoid pulse per coin, largest coin first.
// Define TROCO_MOEDA100_EN to enable the 1.00 coin (moeda100); otherwise only 0.50/0.25 are used.
module dispensador_troco #(
  parameter int unsigned PULSO_CICLOS     = 350,
  parameter int unsigned INTERVALO_CICLOS = 350
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [4:0] soma,
  input  logic [1:0] chbebida,
  output logic       moeda100,
  output logic       moeda050,
  output logic       moeda025,
  output logic       ocupado,
  output logic       concluido,
  output logic       erro_troco,
  output logic [4:0] troco_restante
);

  localparam int unsigned CNT_MAX = (PULSO_CICLOS > INTERVALO_CICLOS) ? PULSO_CICLOS
                                                                      : INTERVALO_CICLOS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    OCIOSO,
    CALCULA,
    PULSO,
    INTERVALO,
    FIM
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       restante_q, restante_d;
  logic             m100_q, m100_d;
  logic             m050_q, m050_d;
  logic             m025_q, m025_d;
  logic             ocup_q, ocup_d;
  logic             concl_q, concl_d;
  logic             erro_q, erro_d;

  logic [4:0]       preco;
  logic             sel100, sel050, sel025;
  logic [4:0]       moeda_val;

  assign preco = 5'd4 + {2'b00, chbebida, 1'b0};

  // Greedy coin choice for the change currently owed.
  always_comb begin
    sel100    = 1'b0;
    sel050    = 1'b0;
    sel025    = 1'b0;
    moeda_val = 5'd1;
    if (restante_q >= 5'd2) begin
      sel050    = 1'b1;
      moeda_val = 5'd2;
    end else begin
      sel025    = 1'b1;
    end
`ifdef TROCO_MOEDA100_EN
    if (restante_q >= 5'd4) begin
      sel100    = 1'b1;
      sel050    = 1'b0;
      sel025    = 1'b0;
      moeda_val = 5'd4;
    end
`endif
  end

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q + 1'b1;
    restante_d = restante_q;
    erro_d     = 1'b0;
    case (estado_q)
      OCIOSO: begin
        cnt_d = '0;
        // The price check runs at latch time so erro_troco is registered during CALCULA.
        if (iniciar) begin
          estado_d = CALCULA;
          if (soma < preco) begin
            erro_d     = 1'b1;
            restante_d = '0;
          end else begin
            restante_d = soma - preco;
          end
        end
      end
      CALCULA: begin
        if (erro_q)                  estado_d = OCIOSO;
        else if (restante_q == 5'd0) estado_d = FIM;
        else                         estado_d = PULSO;
      end
      PULSO: begin
        if (cnt_q == CNT_W'(PULSO_CICLOS - 1)) begin
          restante_d = restante_q - moeda_val;
          estado_d   = INTERVALO;
        end
      end
      INTERVALO: begin
        if (cnt_q == CNT_W'(INTERVALO_CICLOS - 1)) begin
          estado_d = (restante_q != 5'd0) ? PULSO : FIM;
        end
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    if (estado_d != estado_q) cnt_d = '0;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    m100_d  = (estado_d == PULSO) && sel100;
    m050_d  = (estado_d == PULSO) && sel050;
    m025_d  = (estado_d == PULSO) && sel025;
    ocup_d  = (estado_d != OCIOSO);
    concl_d = (estado_d == FIM);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      cnt_q      <= '0;
      restante_q <= '0;
      m100_q     <= 1'b0;
      m050_q     <= 1'b0;
      m025_q     <= 1'b0;
      ocup_q     <= 1'b0;
      concl_q    <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      restante_q <= restante_d;
      m100_q     <= m100_d;
      m050_q     <= m050_d;
      m025_q     <= m025_d;
      ocup_q     <= ocup_d;
      concl_q    <= concl_d;
      erro_q     <= erro_d;
    end
  end

`ifdef TROCO_MOEDA100_EN
  assign moeda100 = m100_q;
`else
  assign moeda100 = 1'b0;
`endif
  assign moeda050       = m050_q;
  assign moeda025       = m025_q;
  assign ocupado        = ocup_q;
  assign concluido      = concl_q;
  assign erro_troco     = erro_q;
  assign troco_restante = restante_q;

endmodule

// File: tb/tb_dispensador_troco.sv
// Bench for dispensador_troco: vector table plus scoreboard of coin/done/error events.
module tb_dispensador_troco;

  localparam int unsigned P = 350;
  localparam int unsigned I = 350;
`ifdef TROCO_MOEDA100_EN
  localparam bit USE100 = 1'b1;
`else
  localparam bit USE100 = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [4:0] soma;
  logic [1:0] chbebida;
  logic       moeda100, moeda050, moeda025;
  logic       ocupado, concluido, erro_troco;
  logic [4:0] troco_restante;

  dispensador_troco #(
    .PULSO_CICLOS    (P),
    .INTERVALO_CICLOS(I)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .soma          (soma),
    .chbebida      (chbebida),
    .moeda100      (moeda100),
    .moeda050      (moeda050),
    .moeda025      (moeda025),
    .ocupado       (ocupado),
    .concluido     (concluido),
    .erro_troco    (erro_troco),
    .troco_restante(troco_restante)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  soma;
    logic [1:0]  beb;
    logic [4:0]  troco;
    int unsigned t_on;
    int unsigned t_off;
  } vec_t;

  // kind: 0=moeda100 rise, 1=moeda050 rise, 2=moeda025 rise, 3=concluido, 4=erro_troco
  typedef struct {
    int          kind;
    int unsigned off;
    int          rest;
  } ev_t;

  ev_t         q[$];
  int          tests = 0;
  int          fails = 0;
  int          viol  = 0;
  int unsigned cyc   = 0;
  int unsigned start = 0;
  int unsigned terminal_off;
  bit          done_flag;
  int          occ_len;
  int unsigned occ_cnt, hi_cnt;
  logic [2:0]  prev_coins;
  logic        prev_ocup;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input int unsigned off, input int rest);
    ev_t e;
    if (q.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_offset", int'(off), int'(e.off));
      check("event_restante", rest, e.rest);
    end
  endtask

  // Reference model: greedy change with the configured coin set.
  task automatic push_expected(input logic [4:0] s, input logic [1:0] b);
    int          price, r, k, v;
    int unsigned off;
    price = 4 + 2 * int'(b);
    if (int'(s) < price) begin
      q.push_back('{4, 1, 0});
    end else begin
      r   = int'(s) - price;
      off = 2;
      while (r > 0) begin
        if (USE100 && r >= 4) begin k = 0; v = 4; end
        else if (r >= 2)      begin k = 1; v = 2; end
        else                  begin k = 2; v = 1; end
        q.push_back('{k, off, r});
        r   -= v;
        off += P + I;
      end
      q.push_back('{3, off, 0});
    end
  endtask

  always @(negedge clock) begin : mon
    logic [2:0]  coins;
    int unsigned offs;
    coins = {moeda100, moeda050, moeda025};
    offs  = cyc - start;
    if (reset) begin
      prev_coins = '0;
      prev_ocup  = 1'b0;
      hi_cnt     = 0;
      occ_cnt    = 0;
    end else begin
      if (coins[2] && !prev_coins[2]) observe(0, offs, int'(troco_restante));
      if (coins[1] && !prev_coins[1]) observe(1, offs, int'(troco_restante));
      if (coins[0] && !prev_coins[0]) observe(2, offs, int'(troco_restante));
      if (concluido) begin
        observe(3, offs, int'(troco_restante));
        terminal_off = offs;
        done_flag    = 1'b1;
      end
      if (erro_troco) begin
        observe(4, offs, int'(troco_restante));
        terminal_off = offs;
        done_flag    = 1'b1;
      end
      if ($countones(coins) > 1 || (coins != 3'b000 && !ocupado)) viol++;
      if (coins != 3'b000) hi_cnt++;
      else if (prev_coins != 3'b000) begin
        check("pulse_width", int'(hi_cnt), int'(P));
        hi_cnt = 0;
      end
      if (ocupado) occ_cnt++;
      else if (prev_ocup) begin
        occ_len = int'(occ_cnt);
        occ_cnt = 0;
      end
      prev_coins = coins;
      prev_ocup  = ocupado;
    end
  end

  task automatic run_vec(input vec_t v, input int unsigned inject_at);
    int unsigned texp, n;
    texp = USE100 ? v.t_on : v.t_off;
    @(negedge clock);
    push_expected(v.soma, v.beb);
    done_flag = 1'b0;
    occ_len   = -1;
    soma      = v.soma;
    chbebida  = v.beb;
    start     = cyc;
    iniciar   = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("troco_after_latch", int'(troco_restante), int'(v.troco));
    n = 0;
    while (!done_flag && n < 12000) begin
      @(negedge clock);
      n++;
      if (inject_at != 0) begin
        if (cyc - start == inject_at) begin
          iniciar  = 1'b1;
          soma     = 5'd31;
          chbebida = 2'd0;
        end else begin
          iniciar = 1'b0;
        end
      end
    end
    iniciar = 1'b0;
    check("completed_in_budget", int'(done_flag), 1);
    check("terminal_offset", int'(terminal_off), int'(texp));
    repeat (3) @(negedge clock);
    check("ocupado_len", occ_len, int'(texp));
    check("troco_final", int'(troco_restante), 0);
    check("scoreboard_drained", q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_coins"}, int'({moeda100, moeda050, moeda025}), 0);
    check({tag, "_ocupado"}, int'(ocupado), 0);
    check({tag, "_concluido"}, int'(concluido), 0);
    check({tag, "_erro"}, int'(erro_troco), 0);
    check({tag, "_troco"}, int'(troco_restante), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{5'd14, 2'd1, 5'd8,  1402, 2802};
    vecs[1] = '{5'd11, 2'd2, 5'd3,  1402, 1402};
    vecs[2] = '{5'd4,  2'd0, 5'd0,  2,    2};
    vecs[3] = '{5'd5,  2'd3, 5'd0,  1,    1};
    vecs[4] = '{5'd31, 2'd0, 5'd27, 5602, 9802};
    vecs[5] = '{5'd10, 2'd3, 5'd0,  2,    2};
    vecs[6] = '{5'd9,  2'd3, 5'd0,  1,    1};
    vecs[7] = '{5'd7,  2'd1, 5'd1,  702,  702};

    reset    = 1'b1;
    iniciar  = 1'b0;
    soma     = '0;
    chbebida = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);

    // Second iniciar mid-pulse and mid-interval must be ignored.
    run_vec(vecs[0], 100);
    run_vec(vecs[0], 500);

    // Reset during the first coin pulse aborts asynchronously.
    @(negedge clock);
    push_expected(5'd14, 2'd1);
    done_flag = 1'b0;
    soma      = 5'd14;
    chbebida  = 2'd1;
    start     = cyc;
    iniciar   = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (99) @(negedge clock);
    check("mid_pulse_coin_high", int'(moeda100 | moeda050 | moeda025), 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    q.delete();
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    run_vec(vecs[0], 0);
    run_vec(vecs[1], 0);

    check("coin_exclusive_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
